// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: walks rom_rc over rounds 1..N and
// hands out round keys 0..N through a valid/ready port.
module aes_key_sched_ctrl #(
   parameter int rounds_p        = 10,
   parameter int rc_addr_width_p = 4,
   parameter int rc_width_p      = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       v_i,
   output logic                       ready_o,
   input  logic [127:0]               key_i,
   output logic                       v_o,
   input  logic                       ready_i,
   output logic [127:0]               key_o,
   output logic [rc_addr_width_p-1:0] round_o,
   output logic                       last_o,
   output logic [rc_addr_width_p-1:0] rc_addr_o,
   input  logic [rc_width_p-1:0]      rc_data_i,
   output logic [31:0]                sbox_word_o,
   input  logic [31:0]                sbox_word_i
);

   typedef enum logic {idle_s, emit_s} state_t;

   localparam logic [rc_addr_width_p-1:0] last_c = rc_addr_width_p'(rounds_p);
   localparam logic [rc_addr_width_p-1:0] one_c  = rc_addr_width_p'(1);

   state_t                     state, state_n;
   logic [127:0]               key_r;
   logic [rc_addr_width_p-1:0] round_r;
   logic                       emit, take, hs, at_last;
   logic [31:0]                w0, w1, w2, w3;
   logic [31:0]                t, n0, n1, n2, n3;

   assign emit    = (state == emit_s);
   assign take    = (state == idle_s) & v_i & ~reset_i;
   assign hs      = emit & ready_i;
   assign at_last = (round_r == last_c);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= idle_s;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         idle_s: if (take) state_n = emit_s;
         emit_s: if (hs && at_last) state_n = idle_s;
         default: state_n = idle_s;
      endcase
   end

   // Next-key path: one AES-128 expansion step from key_r.
   assign w0 = key_r[127:96];
   assign w1 = key_r[95:64];
   assign w2 = key_r[63:32];
   assign w3 = key_r[31:0];
   assign t  = sbox_word_i ^ (32'(rc_data_i) << 24);
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         key_r   <= '0;
         round_r <= '0;
      end else if (take) begin
         key_r   <= key_i;
         round_r <= '0;
      end else if (hs && !at_last) begin
         key_r   <= {n0, n1, n2, n3};
         round_r <= round_r + one_c;
      end
   end

   always_comb begin
      ready_o     = ~emit & ~reset_i;
      v_o         = emit;
      key_o       = emit ? key_r : '0;
      round_o     = emit ? round_r : '0;
      last_o      = emit & at_last;
      rc_addr_o   = '0;
      sbox_word_o = '0;
      if (emit) begin
         // Saturate on the final key so the ROM address stays in range.
         rc_addr_o   = at_last ? last_c : round_r + one_c;
         sbox_word_o = {w3[23:0], w3[31:24]};
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: external rom_rc and S-boxes are modelled
// here, and round keys are checked against a word-level AES-128 expansion.
module tb_aes_key_sched_ctrl;

   logic         clk = 1'b0;
   logic         reset_i;
   logic         v_i;
   logic         ready_o;
   logic [127:0] key_i;
   logic         v_o;
   logic         ready_i;
   logic [127:0] key_o;
   logic [3:0]   round_o;
   logic         last_o;
   logic [3:0]   rc_addr_o;
   logic [7:0]   rc_data_i;
   logic [31:0]  sbox_word_o;
   logic [31:0]  sbox_word_i;

   int n_cmp = 0;
   int n_bad = 0;

   logic [127:0] exp_rk [0:10];
   logic [127:0] got_rk [0:10];

   localparam logic [127:0] fips_k   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] fips_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] fips_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] zero_r1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   always #5 clk = ~clk;

   aes_key_sched_ctrl dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .v_i         (v_i),
      .ready_o     (ready_o),
      .key_i       (key_i),
      .v_o         (v_o),
      .ready_i     (ready_i),
      .key_o       (key_o),
      .round_o     (round_o),
      .last_o      (last_o),
      .rc_addr_o   (rc_addr_o),
      .rc_data_i   (rc_data_i),
      .sbox_word_o (sbox_word_o),
      .sbox_word_i (sbox_word_i)
   );

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box from its definition: GF(2^8) inverse (a^254) then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r, x;
      r = 8'h01;
      x = a;
      for (int i = 1; i < 8; i++) begin
         x = gmul(x, x);
         r = gmul(r, x);
      end
      if (a == 8'h00) r = 8'h00;
      return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] rom_rc(input logic [3:0] a);
      case (a)
         4'd1: return 8'h01;
         4'd2: return 8'h02;
         4'd3: return 8'h04;
         4'd4: return 8'h08;
         4'd5: return 8'h10;
         4'd6: return 8'h20;
         4'd7: return 8'h40;
         4'd8: return 8'h80;
         4'd9: return 8'h1b;
         4'd10: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   assign rc_data_i   = rom_rc(rc_addr_o);
   assign sbox_word_i = sub_word(sbox_word_o);

   // Textbook schedule over 44 words; Rcon generated by repeated doubling.
   task automatic expand(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= 10; r++)
         exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start_job(input logic [127:0] k);
      int n;
      n = 0;
      while (!ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_start", 128'(ready_o), 128'd1);
      v_i   = 1'b1;
      key_i = k;
      @(negedge clk);
      v_i   = 1'b0;
   endtask

   // Walks one job from round 0; optionally pulses a stray key mid-job and
   // optionally holds v_i with the next key across the final handshake.
   task automatic emit_job(input logic [127:0] k, input int rdy_pct,
                           input bit busy, input bit hold,
                           input logic [127:0] nk);
      int idx, cyc;
      expand(k);
      idx = 0;
      cyc = 0;
      while (idx <= 10 && cyc < 400) begin
         check("v_o", 128'(v_o), 128'd1);
         check("ready_busy", 128'(ready_o), 128'd0);
         check("round_o", 128'(round_o), 128'(idx));
         check("key_o", key_o, exp_rk[idx]);
         check("last_o", 128'(last_o), 128'(idx == 10));
         if (idx < 10) check("rc_addr", 128'(rc_addr_o), 128'(idx + 1));
         else          check("rc_addr_max", 128'(rc_addr_o <= 4'd10), 128'd1);
         got_rk[idx] = key_o;
         v_i = 1'b0;
         if (busy && idx == 3) begin
            v_i   = 1'b1;
            key_i = {$urandom, $urandom, $urandom, $urandom};
         end
         if (hold && idx == 10) begin
            v_i   = 1'b1;
            key_i = nk;
         end
         ready_i = ($urandom_range(0, 99) < rdy_pct);
         @(negedge clk);
         cyc++;
         if (ready_i) idx++;
      end
      if (idx <= 10) check("emit_timeout", 128'd0, 128'd1);
      ready_i = 1'b0;
      check("idle_v_o", 128'(v_o), 128'd0);
      check("idle_ready", 128'(ready_o), 128'd1);
   endtask

   task automatic run_job(input logic [127:0] k, input int rdy_pct);
      start_job(k);
      emit_job(k, rdy_pct, 1'b0, 1'b0, 128'd0);
   endtask

   initial begin
      logic [127:0] k1, k2;
      int n;
      reset_i = 1'b1;
      v_i     = 1'b0;
      ready_i = 1'b0;
      key_i   = '0;
      repeat (3) @(negedge clk);
      check("rst_v_o", 128'(v_o), 128'd0);
      check("rst_ready", 128'(ready_o), 128'd0);
      check("rst_key_o", key_o, 128'd0);
      check("rst_round", 128'(round_o), 128'd0);
      check("rst_last", 128'(last_o), 128'd0);
      check("rst_rc_addr", 128'(rc_addr_o), 128'd0);
      check("rst_sbox", 128'(sbox_word_o), 128'd0);
      reset_i = 1'b0;
      #1;
      check("post_rst_ready", 128'(ready_o), 128'd1);
      @(negedge clk);

      run_job(fips_k, 100);
      check("fips_r0", got_rk[0], fips_k);
      check("fips_r1", got_rk[1], fips_r1);
      check("fips_r10", got_rk[10], fips_r10);

      run_job(128'd0, 100);
      check("zero_r1", got_rk[1], zero_r1);
      check("zero_r10", got_rk[10], zero_r10);

      run_job(fips_k, 50);
      check("bp_r1", got_rk[1], fips_r1);
      check("bp_r10", got_rk[10], fips_r10);

      start_job(fips_k);
      emit_job(fips_k, 60, 1'b1, 1'b0, 128'd0);
      check("busy_r10", got_rk[10], fips_r10);

      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = {$urandom, $urandom, $urandom, $urandom};
      start_job(k1);
      emit_job(k1, 70, 1'b0, 1'b1, k2);
      @(negedge clk);
      v_i = 1'b0;
      emit_job(k2, 100, 1'b0, 1'b0, 128'd0);

      for (int j = 0; j < 3; j++)
         run_job({$urandom, $urandom, $urandom, $urandom}, 60);

      start_job(fips_k);
      ready_i = 1'b1;
      n = 0;
      while (round_o != 4'd5 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("reach_round5", 128'(round_o), 128'd5);
      #2 reset_i = 1'b1;
      #1;
      check("abort_v_o", 128'(v_o), 128'd0);
      check("abort_ready", 128'(ready_o), 128'd0);
      check("abort_key_o", key_o, 128'd0);
      ready_i = 1'b0;
      @(negedge clk);
      reset_i = 1'b0;
      #1;
      check("rel_ready", 128'(ready_o), 128'd1);
      check("rel_v_o", 128'(v_o), 128'd0);
      k1 = {$urandom, $urandom, $urandom, $urandom};
      run_job(k1, 80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
